// File: rtl/timer_sequencer.sv
// timer_sequencer: drives a 16-bit timer peripheral through its register bus.
// A start command stops the timer, loads the 64-bit period, then starts it.
// Each timeout interrupt is acknowledged with a status-register clear and
// counted. A stop command halts the timer.
// Optional feature (macro TIMER_SEQUENCER_SNAPSHOT_EN): snapshot the live
// 64-bit counter through the snap registers and present it on snap_value.
// All outputs come straight from flops. The bus flops are loaded from the
// decode of the next state, so each access occupies exactly the cycle its
// state is active.
module timer_sequencer #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic [63:0]       cmd_period,
  input  logic              cmd_continuous,
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  input  logic              cmd_snap,
  output logic              snap_valid,
  output logic [63:0]       snap_value,
`endif
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [3:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HALT   = 4'd1,
    S_P0     = 4'd2,
    S_P1     = 4'd3,
    S_P2     = 4'd4,
    S_P3     = 4'd5,
    S_CTRL   = 4'd6,
    S_RUN    = 4'd7,
    S_CLR    = 4'd8,
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    S_STOP   = 4'd9,
    S_SNAP_W = 4'd10,
    S_SNAP_0 = 4'd11,
    S_SNAP_1 = 4'd12,
    S_SNAP_2 = 4'd13,
    S_SNAP_3 = 4'd14,
    S_SNAP_D = 4'd15
`else
    S_STOP   = 4'd9
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         period_q, period_d;
  logic                cont_q, cont_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;
  logic                running_q, running_d;
  logic                cs_q, cs_d;
  logic                wn_q, wn_d;
  logic [3:0]          addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;

  // Next-state, command capture and tick bookkeeping.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    cont_d       = cont_q;
    tick_count_d = tick_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d      = S_HALT;
          period_d     = cmd_period;
          cont_d       = cmd_continuous;
          tick_count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: state_d = S_P0;
      S_P0:   state_d = S_P1;
      S_P1:   state_d = S_P2;
      S_P2:   state_d = S_P3;
      S_P3:   state_d = S_CTRL;
      S_CTRL: state_d = S_RUN;
      S_RUN: begin
        // start beats stop beats snapshot beats timeout
        if (cmd_start) begin
          state_d      = S_HALT;
          period_d     = cmd_period;
          cont_d       = cmd_continuous;
          tick_count_d = '0;
        end else if (cmd_stop) begin
          state_d = S_STOP;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
        end else if (cmd_snap) begin
          state_d = S_SNAP_W;
`endif
        end else if (tmr_irq) begin
          state_d      = S_CLR;
          tick_count_d = tick_count_q + TICK_W'(1);
        end else begin
          state_d = S_RUN;
        end
      end
      S_CLR: begin
        if (cont_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STOP: state_d = S_IDLE;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      S_SNAP_W: state_d = S_SNAP_0;
      S_SNAP_0: state_d = S_SNAP_1;
      S_SNAP_1: state_d = S_SNAP_2;
      S_SNAP_2: state_d = S_SNAP_3;
      S_SNAP_3: state_d = S_SNAP_D;
      S_SNAP_D: state_d = S_RUN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Bus access and status flags for the state about to become active.
  always_comb begin
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    addr_d    = 4'd0;
    wdata_d   = 16'h0000;
    tick_d    = (state_d == S_CLR);
    running_d = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE) && (state_d != S_RUN);
    case (state_d)
      S_HALT: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0008; end
      S_P0:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd2; wdata_d = period_d[15:0];  end
      S_P1:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd3; wdata_d = period_d[31:16]; end
      S_P2:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd4; wdata_d = period_d[47:32]; end
      S_P3:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd5; wdata_d = period_d[63:48]; end
      // START, CONT, ITO
      S_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = {13'd0, 1'b1, cont_d, 1'b1}; end
      S_CLR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd0; wdata_d = 16'h0000; end
      S_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0008; end
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      S_SNAP_W: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd6; wdata_d = 16'h0000; end
      S_SNAP_0: begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 4'd6; end
      S_SNAP_1: begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 4'd7; end
      S_SNAP_2: begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 4'd8; end
      S_SNAP_3: begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 4'd9; end
`endif
      default: begin cs_d = 1'b0; wn_d = 1'b1; addr_d = 4'd0; wdata_d = 16'h0000; end
    endcase
  end

  // State, captured command and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      period_q     <= 64'd0;
      cont_q       <= 1'b0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= 4'd0;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      tick_count_q <= tick_count_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign running        = running_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = wdata_q;

`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  logic [63:0] snap_q, snap_d;
  logic        snap_valid_q, snap_valid_d;

  // Read data lags its address by one cycle, so each halfword is taken
  // in the state after the one that addressed it.
  always_comb begin
    snap_d       = snap_q;
    snap_valid_d = 1'b0;
    case (state_q)
      S_SNAP_1: snap_d[15:0]  = tmr_readdata;
      S_SNAP_2: snap_d[31:16] = tmr_readdata;
      S_SNAP_3: snap_d[47:32] = tmr_readdata;
      S_SNAP_D: begin
        snap_d[63:48] = tmr_readdata;
        snap_valid_d  = 1'b1;
      end
      default: snap_d = snap_q;
    endcase
  end

  // Snapshot value and its one-cycle valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q       <= 64'd0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_value = snap_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_readdata_s;
  assign unused_readdata_s = ^tmr_readdata;
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer: directed commands push the expected
// bus accesses and tick counts; a negedge monitor pops and compares them.
module tb_timer_sequencer;
  localparam int TICK_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_start = 1'b0;
  logic              cmd_stop = 1'b0;
  logic [63:0]       cmd_period = 64'd0;
  logic              cmd_continuous = 1'b0;
  logic              tmr_irq = 1'b0;
  logic [15:0]       tmr_readdata = 16'h0000;
  logic              busy, running, tick;
  logic [TICK_W-1:0] tick_count;
  logic [3:0]        tmr_address;
  logic              tmr_chipselect, tmr_write_n;
  logic [15:0]       tmr_writedata;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  logic              cmd_snap = 1'b0;
  logic              snap_valid;
  logic [63:0]       snap_value;
  int                snap_pulses = 0;
`endif

  timer_sequencer #(.TICK_W(TICK_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    .cmd_snap(cmd_snap), .snap_valid(snap_valid), .snap_value(snap_value),
`endif
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [20:0]       exp_bus_q[$];   // {write_n, address, writedata}
  logic [TICK_W-1:0] exp_tick_q[$];  // tick_count expected at each tick

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
    exp_bus_q.push_back({1'b0, a, d});
  endtask

  task automatic push_prog(input logic [63:0] p, input logic c);
    push_wr(4'd1, 16'h0008);
    push_wr(4'd2, p[15:0]);
    push_wr(4'd3, p[31:16]);
    push_wr(4'd4, p[47:32]);
    push_wr(4'd5, p[63:48]);
    push_wr(4'd1, {13'd0, 1'b1, c, 1'b1});
  endtask

  // Pulse cmd_start; returns just after the edge that sampled it.
  task automatic start(input logic [63:0] p, input logic c);
    cmd_start = 1'b1;
    cmd_period = p;
    cmd_continuous = c;
    cycle(1);
    cmd_start = 1'b0;
  endtask

  task automatic pulse_irq();
    tmr_irq = 1'b1;
    cycle(1);
    tmr_irq = 1'b0;
  endtask

  // Monitor: every bus access and every tick must match the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (tmr_chipselect) begin
        if (exp_bus_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL bus_unexpected: got wn=%0b addr=%0d data=0x%0h expected no access",
                   tmr_write_n, tmr_address, tmr_writedata);
        end else begin
          check("bus_access", {43'd0, tmr_write_n, tmr_address, tmr_writedata}, {43'd0, exp_bus_q.pop_front()});
        end
      end
      if (tick) begin
        if (exp_tick_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tick_unexpected: got tick=1 count=%0d expected no tick", tick_count);
        end else begin
          check("tick_count_at_tick", 64'(tick_count), 64'(exp_tick_q.pop_front()));
        end
      end
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      if (snap_valid) begin
        snap_pulses++;
        check("snap_value", snap_value, 64'h4444_3333_2222_1111);
      end
`endif
    end
  end

`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  // Peripheral read model: data appears the cycle after the address.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n) begin
      case (tmr_address)
        4'd6:    tmr_readdata <= 16'h1111;
        4'd7:    tmr_readdata <= 16'h2222;
        4'd8:    tmr_readdata <= 16'h3333;
        4'd9:    tmr_readdata <= 16'h4444;
        default: tmr_readdata <= 16'hDEAD;
      endcase
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycle(2);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_tick_count", 64'(tick_count), 64'd0);
    check("rst_bus", {42'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {42'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
    cycle(1);
    reset = 1'b0;
    cycle(2);

    // Programming sequence, continuous mode
    push_prog(64'h0000_0000_0001_86A0, 1'b1);
    start(64'h0000_0000_0001_86A0, 1'b1);
    check("prog_busy", 64'(busy), 64'd1);
    cycle(5);
    check("ctrl_not_running", 64'(running), 64'd0);
    cycle(1);
    check("running_cycle7", 64'(running), 64'd1);
    check("run_not_busy", 64'(busy), 64'd0);

    // Three timeouts in continuous mode
    for (int i = 1; i <= 3; i++) begin
      push_wr(4'd0, 16'h0000);
      exp_tick_q.push_back(TICK_W'(i));
      pulse_irq();
      cycle(9);
    end
    check("cont_tick_count", 64'(tick_count), 64'd3);
    check("cont_running", 64'(running), 64'd1);

    // Restart from RUN in one-shot mode, then a single timeout
    push_prog(64'h0123_4567_89AB_CDEF, 1'b0);
    start(64'h0123_4567_89AB_CDEF, 1'b0);
    check("restart_clears_count", 64'(tick_count), 64'd0);
    cycle(6);
    check("oneshot_running", 64'(running), 64'd1);
    push_wr(4'd0, 16'h0000);
    exp_tick_q.push_back(TICK_W'(1));
    pulse_irq();
    cycle(1);
    check("oneshot_idle_running", 64'(running), 64'd0);
    check("oneshot_idle_busy", 64'(busy), 64'd0);

    // irq outside RUN is ignored
    tmr_irq = 1'b1;
    cycle(3);
    tmr_irq = 1'b0;
    check("idle_irq_ignored", 64'(tick_count), 64'd1);

    // Stop and irq together: stop wins, no tick
    push_prog(64'd5, 1'b1);
    start(64'd5, 1'b1);
    cycle(6);
    check("stop_pre_running", 64'(running), 64'd1);
    push_wr(4'd1, 16'h0008);
    cmd_stop = 1'b1;
    tmr_irq = 1'b1;
    cycle(1);
    cmd_stop = 1'b0;
    tmr_irq = 1'b0;
    check("stop_busy", 64'(busy), 64'd1);
    cycle(1);
    check("stop_idle_running", 64'(running), 64'd0);
    check("stop_idle_busy", 64'(busy), 64'd0);
    check("stop_no_tick", 64'(tick_count), 64'd0);

    // cmd_start during P2 is dropped
    push_prog(64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    start(64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    cycle(3);
    cmd_start = 1'b1;
    cmd_period = 64'h1;
    cmd_continuous = 1'b0;
    cycle(1);
    cmd_start = 1'b0;
    cycle(2);
    check("drop_running", 64'(running), 64'd1);
    cycle(3);
    check("drop_no_extra", 64'(exp_bus_q.size()), 64'd0);

`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    // Snapshot from RUN
    push_wr(4'd6, 16'h0000);
    for (int a = 6; a <= 9; a++) exp_bus_q.push_back({1'b1, 4'(a), 16'h0000});
    cmd_snap = 1'b1;
    cycle(1);
    cmd_snap = 1'b0;
    check("snap_busy", 64'(busy), 64'd1);
    cycle(6);
    check("snap_back_running", 64'(running), 64'd1);
    cycle(3);
    check("snap_pulses", 64'(snap_pulses), 64'd1);
`endif

    // Reset during P1 abandons the sequence
    push_wr(4'd1, 16'h0008);
    push_wr(4'd2, 16'h1234);
    start(64'h1234, 1'b1);
    cycle(2);
    reset = 1'b1;
    #2;
    check("midrst_bus", {42'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {42'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
    check("midrst_tick_count", 64'(tick_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_running", 64'(running), 64'd0);
    cycle(2);
    reset = 1'b0;
    cycle(10);
    check("final_bus_queue_empty", 64'(exp_bus_q.size()), 64'd0);
    check("final_tick_queue_empty", 64'(exp_tick_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter TICK_W, default 32, width of tick counter.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_start  input  1  one-cycle pulse: program period and start timer; sampled only in IDLE or RUN.
REQ-005 cmd_stop  input  1  one-cycle pulse: stop timer; sampled only in RUN.
REQ-006 cmd_period  input  64  period value minus one, captured on accepted cmd_start.
REQ-007 cmd_continuous  input  1  continuous-mode bit, captured on accepted cmd_start.
REQ-008 busy  output  1  high in every state except IDLE and RUN.
REQ-009 running  output  1  high in RUN only.
REQ-010 tick  output  1  one-cycle pulse per serviced timeout.
REQ-011 tick_count  output  TICK_W  serviced timeouts since last accepted cmd_start.
REQ-012 tmr_address  output  4  register index to timer peripheral.
REQ-013 tmr_chipselect  output  1  peripheral select.
REQ-014 tmr_write_n  output  1  active-low write strobe.
REQ-015 tmr_writedata  output  16  write data.
REQ-016 tmr_readdata  input  16  read data, valid one cycle after the address is presented.
REQ-017 tmr_irq  input  1  level timeout interrupt from peripheral.

Function
REQ-018 Bus access: each state issues at most one access, lasting exactly one cycle; no wait states.
REQ-019 Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 States: IDLE, HALT, P0, P1, P2, P3, CTRL, RUN, CLR, STOP; one state per cycle except IDLE/RUN.
REQ-021 IDLE/RUN + cmd_start: capture period/mode, clear tick_count, go to HALT.
REQ-022 HALT: write address 1, data 0x0008 (stop, ITO off).
REQ-023 P0..P3: write addresses 2..5 with cmd_period[15:0], [31:16], [47:32], [63:48] respectively.
REQ-024 CTRL: write address 1, data {13'b0, 1, continuous, 1} (START, CONT, ITO); next state RUN.
REQ-025 RUN + tmr_irq: go to CLR; CLR writes address 0, data 0; tick=1 in the CLR cycle; tick_count increments by 1, wrapping at 2^TICK_W.
REQ-026 CLR next state: RUN if continuous, else IDLE.
REQ-027 RUN + cmd_stop: go to STOP; STOP writes address 1, data 0x0008, then IDLE.
REQ-028 RUN priority: cmd_start > cmd_stop > tmr_irq; a pending irq is re-evaluated after the next RUN entry.
REQ-029 Commands arriving while busy are dropped, with no queuing.
REQ-030 tmr_irq is ignored outside RUN; the one-cycle blind window after CLR is tolerated because the peripheral drops irq one cycle after the status write.

Reset
REQ-031 While reset is high: state=IDLE, bus idle per REQ-019, tick=0, tick_count=0, running=0, busy=0, captured period=0, continuous=0.
REQ-032 Reset mid-sequence abandons the sequence with no further bus accesses until a new cmd_start.

Configuration
REQ-033 Macro TIMER_SEQUENCER_SNAPSHOT_EN.
REQ-034 With the macro defined: add input cmd_snap (sampled in RUN, priority below cmd_stop and above irq), output snap_valid (1) and output snap_value (64).
REQ-035 Snapshot sequence: write address 6, data 0; read addresses 6..9 on consecutive cycles; capture each halfword one cycle later; assert snap_valid for one cycle with the assembled value; return to RUN; 6 cycles total.
REQ-036 With the macro undefined: no such ports or states; behaviour otherwise identical.

Verification
REQ-037 cmd_start, period=0x0000_0000_0001_86A0, cont=1 -> writes (1,0x0008),(2,0x86A0),(3,0x0001),(4,0),(5,0),(1,0x0007); running high at cycle 7.
REQ-038 In RUN, pulse tmr_irq 3 times, 10 cycles apart -> 3 writes (0,0x0000), 3 tick pulses, tick_count=3, running stays high.
REQ-039 cont=0 start, irq -> CLR write, tick=1, then IDLE, running=0.
REQ-040 RUN with cmd_stop and tmr_irq in the same cycle -> write (1,0x0008), no tick, IDLE.
REQ-041 cmd_start during P2 dropped; reset asserted during P1 -> bus idle immediately, tick_count=0.
REQ-042 With the snapshot macro: readdata returns 0x1111,0x2222,0x3333,0x4444 -> snap_value=0x4444_3333_2222_1111, single snap_valid pulse.
